// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory signal bundle for the IMEM loader.
// slave is the loader's view. master is the view of the block that
// drives the byte stream and control inputs.
interface imem_loader_if;
    logic        Start;
    logic [10:0] Length;
    logic        Abort;
    logic [7:0]  Byte_in;
    logic        Byte_valid;
    logic        Byte_ready;
    logic        Mem_we;
    logic [11:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic        Cpu_hold;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport slave (
        input  Start, Length, Abort, Byte_in, Byte_valid,
        output Byte_ready, Mem_we, Mem_addr, Mem_wdata,
               Cpu_hold, Busy, Done, Error
    );

    modport master (
        output Start, Length, Abort, Byte_in, Byte_valid,
        input  Byte_ready, Mem_we, Mem_addr, Mem_wdata,
               Cpu_hold, Busy, Done, Error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into 32-bit words and
// writes them to sequential word-aligned addresses while holding the CPU.
module imem_loader #(
    parameter int WORDS      = 1024,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [11:0] LP_WORDS = 12'(WORDS);

    state_t      r_state;
    logic [10:0] r_len;
    logic [10:0] r_idx;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] r_wdata;
    logic [11:0] r_addr;
    logic        r_ready;
    logic        r_we;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_word;
    logic [10:0] w_idx_next;
    logic        w_bad_len;
    logic        w_accept;

    // Word being assembled with the incoming byte placed per byte order.
    always_comb begin
        w_word = r_word;
        if (BIG_ENDIAN) begin
            w_word = {r_word[23:0], bus.Byte_in};
        end else begin
            w_word = {bus.Byte_in, r_word[31:8]};
        end
    end

    assign w_idx_next = r_idx + 11'd1;
    assign w_bad_len  = (bus.Length == 11'd0) || ({1'b0, bus.Length} > LP_WORDS);
    assign w_accept   = bus.Byte_valid && r_ready;

    // Loader FSM; every output flag is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        if (w_bad_len) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_len   <= bus.Length;
                            r_idx   <= '0;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (bus.Abort) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_word <= w_word;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_wdata <= w_word;
                            r_addr  <= {r_idx[9:0], 2'b00};
                            r_we    <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    if (bus.Abort) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_len) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= S_RECV;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Abort must kill the write strobe in the same cycle it is raised.
    assign bus.Mem_we     = r_we & ~bus.Abort;
    assign bus.Byte_ready = r_ready;
    assign bus.Mem_addr   = r_addr;
    assign bus.Mem_wdata  = r_wdata;
    assign bus.Busy       = r_busy;
    assign bus.Cpu_hold   = r_busy;
    assign bus.Done       = r_done;
    assign bus.Error      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: big-endian instance for most scenarios,
// little-endian instance for byte-order placement.
module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if be_if ();
    imem_loader_if le_if ();

    imem_loader u_be (.clk(clk), .rst_n(rst_n), .bus(be_if));
    imem_loader #(.WORDS(1024), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst_n(rst_n), .bus(le_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Write/Done/Busy monitors for both instances
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [11:0] le_wa_q[$];
    logic [31:0] le_wd_q[$];
    int done_cnt = 0;
    int le_done_cnt = 0;
    bit busy_seen = 0;
    bit ready_in_we = 0;

    always @(negedge clk) begin
        if (be_if.Mem_we === 1'b1) begin
            wa_q.push_back(be_if.Mem_addr);
            wd_q.push_back(be_if.Mem_wdata);
            if (be_if.Byte_ready === 1'b1) ready_in_we = 1;
        end
        if (be_if.Done === 1'b1) done_cnt++;
        if (be_if.Busy === 1'b1) busy_seen = 1;
        if (le_if.Mem_we === 1'b1) begin
            le_wa_q.push_back(le_if.Mem_addr);
            le_wd_q.push_back(le_if.Mem_wdata);
        end
        if (le_if.Done === 1'b1) le_done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        le_wa_q.delete();
        le_wd_q.delete();
        done_cnt = 0;
        le_done_cnt = 0;
        busy_seen = 0;
        ready_in_we = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic start_load(input logic [10:0] len);
        be_if.Start  = 1'b1;
        be_if.Length = len;
        step();
        be_if.Start  = 1'b0;
    endtask

    // Offer one byte and hold it until accepted (bounded), gap cycles after.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        be_if.Byte_in    = b;
        be_if.Byte_valid = 1'b1;
        while (!acc && guard < 20) begin
            acc = (be_if.Byte_ready === 1'b1);
            step();
            guard++;
        end
        be_if.Byte_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL byte_accept_timeout: byte %h never accepted", b);
        end
        for (int g = 0; g < gap; g++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({be_if.Byte_ready, be_if.Mem_we, be_if.Cpu_hold, be_if.Busy, be_if.Done, be_if.Error} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {be_if.Byte_ready, be_if.Mem_we, be_if.Cpu_hold, be_if.Busy, be_if.Done, be_if.Error});
        else n_pass++;
        chk("reset_addr", {20'd0, be_if.Mem_addr}, 32'd0);
        chk("reset_wdata", be_if.Mem_wdata, 32'd0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_two_words();
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        clear_mon();
        start_load(11'd2);
        chk("be_busy_after_start", {31'd0, be_if.Busy}, 32'd1);
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 0);
        chk("be_we_latency", {31'd0, be_if.Mem_we}, 32'd1);
        chk("be_ready_in_write", {31'd0, be_if.Byte_ready}, 32'd0);
        step();
        chk("be_ready_after_write", {31'd0, be_if.Byte_ready}, 32'd1);
        for (int i = 4; i < 8; i++) send_byte(bytes[i], 0);
        for (int i = 0; i < 4; i++) step();
        chk("be_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("be_addr0", {20'd0, wa_q[0]}, 32'h000);
            chk("be_data0", wd_q[0], 32'h12345678);
            chk("be_addr1", {20'd0, wa_q[1]}, 32'h004);
            chk("be_data1", wd_q[1], 32'h9ABCDEF0);
        end
        chk("be_done_pulses", done_cnt, 32'd1);
        chk("be_error", {31'd0, be_if.Error}, 32'd0);
    endtask

    task automatic test_little_endian();
        logic [7:0] bytes [4];
        bit acc;
        int guard;
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        clear_mon();
        le_if.Start  = 1'b1;
        le_if.Length = 11'd1;
        step();
        le_if.Start  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            guard = 0;
            le_if.Byte_in    = bytes[i];
            le_if.Byte_valid = 1'b1;
            while (!acc && guard < 20) begin
                acc = (le_if.Byte_ready === 1'b1);
                step();
                guard++;
            end
            le_if.Byte_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) step();
        chk("le_nwrites", le_wa_q.size(), 32'd1);
        if (le_wa_q.size() == 1) begin
            chk("le_addr0", {20'd0, le_wa_q[0]}, 32'h000);
            chk("le_data0", le_wd_q[0], 32'h78563412);
        end
        chk("le_done_pulses", le_done_cnt, 32'd1);
    endtask

    task automatic test_toggle_valid();
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        clear_mon();
        start_load(11'd2);
        for (int i = 0; i < 8; i++) send_byte(bytes[i], 1);
        for (int i = 0; i < 4; i++) step();
        chk("tog_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("tog_data0", wd_q[0], 32'h12345678);
            chk("tog_addr1", {20'd0, wa_q[1]}, 32'h004);
            chk("tog_data1", wd_q[1], 32'h9ABCDEF0);
        end
        chk("tog_ready_during_we", {31'd0, ready_in_we}, 32'd0);
        chk("tog_done_pulses", done_cnt, 32'd1);
    endtask

    task automatic test_bad_length();
        logic [10:0] lens [2];
        lens = '{11'd0, 11'd1025};
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            start_load(lens[k]);
            chk($sformatf("bad%0d_error", lens[k]), {31'd0, be_if.Error}, 32'd1);
            for (int i = 0; i < 4; i++) step();
            chk($sformatf("bad%0d_nwrites", lens[k]), wa_q.size(), 32'd0);
            chk($sformatf("bad%0d_done", lens[k]), done_cnt, 32'd1);
            chk($sformatf("bad%0d_busy_seen", lens[k]), {31'd0, busy_seen}, 32'd0);
            chk($sformatf("bad%0d_error_sticky", lens[k]), {31'd0, be_if.Error}, 32'd1);
        end
    endtask

    task automatic test_abort();
        logic [7:0] bytes [6];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        clear_mon();
        start_load(11'd3);
        chk("abt_error_cleared", {31'd0, be_if.Error}, 32'd0);
        for (int i = 0; i < 6; i++) send_byte(bytes[i], 0);
        be_if.Abort = 1'b1;
        step();
        be_if.Abort = 1'b0;
        chk("abt_cpu_hold", {31'd0, be_if.Cpu_hold}, 32'd0);
        chk("abt_ready", {31'd0, be_if.Byte_ready}, 32'd0);
        chk("abt_error", {31'd0, be_if.Error}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("abt_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            chk("abt_addr0", {20'd0, wa_q[0]}, 32'h000);
            chk("abt_data0", wd_q[0], 32'h12345678);
        end
        chk("abt_done", done_cnt, 32'd0);
        // Following load starts clean: Error cleared, no partial bytes left over
        clear_mon();
        start_load(11'd1);
        chk("abt_restart_error", {31'd0, be_if.Error}, 32'd0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        for (int i = 0; i < 3; i++) step();
        chk("abt_restart_data", (wd_q.size() == 1) ? wd_q[0] : 32'hXXXXXXXX, 32'h11223344);
        chk("abt_restart_done", done_cnt, 32'd1);
        // Abort raised during the WRITE cycle kills the strobe immediately
        clear_mon();
        start_load(11'd1);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        send_byte(8'hA3, 0);
        send_byte(8'hA4, 0);
        be_if.Abort = 1'b1;
        #1;
        chk("abtw_we_suppressed", {31'd0, be_if.Mem_we}, 32'd0);
        step();
        be_if.Abort = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("abtw_nwrites", wa_q.size(), 32'd0);
        chk("abtw_done", done_cnt, 32'd0);
        chk("abtw_error", {31'd0, be_if.Error}, 32'd1);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        start_load(11'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({be_if.Byte_ready, be_if.Mem_we, be_if.Cpu_hold, be_if.Busy, be_if.Done, be_if.Error} !== 6'b0)
            $display("FAIL midrst_flags: got %b expected 000000",
                     {be_if.Byte_ready, be_if.Mem_we, be_if.Cpu_hold, be_if.Busy, be_if.Done, be_if.Error});
        else n_pass++;
        chk("midrst_addr", {20'd0, be_if.Mem_addr}, 32'd0);
        chk("midrst_wdata", be_if.Mem_wdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        clear_mon();
        start_load(11'd1);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        for (int i = 0; i < 3; i++) step();
        chk("midrst_nwrites", wa_q.size(), 32'd1);
        chk("midrst_data", (wd_q.size() == 1) ? wd_q[0] : 32'hXXXXXXXX, 32'hDEADBEEF);
        chk("midrst_done", done_cnt, 32'd1);
        chk("midrst_error", {31'd0, be_if.Error}, 32'd0);
    endtask

    task automatic test_full_length();
        clear_mon();
        start_load(11'd1024);
        for (int i = 0; i < 4096; i++) send_byte(8'(i), 0);
        for (int i = 0; i < 4; i++) step();
        chk("full_nwrites", wa_q.size(), 32'd1024);
        if (wa_q.size() == 1024) begin
            chk("full_last_addr", {20'd0, wa_q[1023]}, 32'hFFC);
            chk("full_last_data", wd_q[1023], 32'hFCFDFEFF);
            chk("full_mid_addr", {20'd0, wa_q[512]}, 32'h800);
        end
        chk("full_done", done_cnt, 32'd1);
        chk("full_error", {31'd0, be_if.Error}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        be_if.Start = 1'b0;
        be_if.Length = '0;
        be_if.Abort = 1'b0;
        be_if.Byte_in = '0;
        be_if.Byte_valid = 1'b0;
        le_if.Start = 1'b0;
        le_if.Length = '0;
        le_if.Abort = 1'b0;
        le_if.Byte_in = '0;
        le_if.Byte_valid = 1'b0;
        test_reset();
        test_two_words();
        test_little_endian();
        test_toggle_valid();
        test_bad_length();
        test_abort();
        test_reset_mid();
        test_full_length();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 1024, meaning instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1, meaning the first received byte of a word lands in bits [31:24]; when 0 it lands in bits [7:0].
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port Start, input, 1 bit: load request, sampled only in IDLE.
REQ-007 The block SHALL have port Length, input, 11 bits: number of words to load, sampled with Start.
REQ-008 The block SHALL have port Abort, input, 1 bit: cancels an in-progress load.
REQ-009 The block SHALL have port Byte_in, input, 8 bits: byte stream data.
REQ-010 The block SHALL have port Byte_valid, input, 1 bit: Byte_in is valid.
REQ-011 The block SHALL have port Byte_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-012 The block SHALL have port Mem_we, output, 1 bit: instruction-memory write strobe.
REQ-013 The block SHALL have port Mem_addr, output, 12 bits: byte address, word-aligned ([1:0]=0), matching the 12-bit byte addressing of the instruction memory.
REQ-014 The block SHALL have port Mem_wdata, output, 32 bits: assembled word.
REQ-015 The block SHALL have port Cpu_hold, output, 1 bit: keeps the CPU stalled while memory is being rewritten.
REQ-016 The block SHALL have port Busy, output, 1 bit: the FSM is in RECV or WRITE.
REQ-017 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-018 The block SHALL have port Error, output, 1 bit: sticky error flag.

Function
REQ-019 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-020 In IDLE with Start=1: if Length==0 or Length>WORDS, the block SHALL set Error=1 and go to DONE; otherwise it SHALL clear Error, word index, and byte count, then go to RECV.
REQ-021 Start SHALL be ignored in any state other than IDLE.
REQ-022 Byte_ready SHALL be 1 only in RECV; a byte SHALL be accepted only on cycles where Byte_valid and Byte_ready are both 1.
REQ-023 Each accepted byte SHALL be placed per BIG_ENDIAN; the 2-bit byte count SHALL increment on each accepted byte, and the 4th accepted byte SHALL transition the FSM to WRITE on the same edge.
REQ-024 WRITE SHALL last exactly one cycle with Mem_we=1, Mem_addr={word_index,2'b00}, and Mem_wdata holding the complete word.
REQ-025 After WRITE, the word index SHALL increment; if the new index equals Length, the FSM SHALL go to DONE, else to RECV.
REQ-026 Latency from acceptance of a word's 4th byte to Mem_we SHALL be 1 cycle; the next Byte_ready SHALL assert the cycle after Mem_we.
REQ-027 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-028 Mem_we SHALL be 0 in every state except WRITE; Mem_addr and Mem_wdata are don't-care when Mem_we=0 but SHALL hold their last values.
REQ-029 Cpu_hold SHALL equal Busy.
REQ-030 Abort=1 in RECV or WRITE SHALL force IDLE on the next edge, suppress Mem_we in that cycle, discard any partial word, set Error=1, and produce no Done pulse; Abort SHALL have priority over byte acceptance and write.
REQ-031 Abort in IDLE or DONE SHALL be ignored.
REQ-032 Error SHALL remain set until the next Start accepted in IDLE.
REQ-033 The last word SHALL be written at Mem_addr={Length-1,2'b00}; with Length=WORDS=1024 this is 12'hFFC, and the index SHALL never wrap.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and set Byte_ready, Mem_we, Cpu_hold, Busy, Done, Error, Mem_addr, Mem_wdata, word index, and byte count all to 0, including mid-load.

Verification
REQ-035 Length=2, BIG_ENDIAN=1, bytes 12 34 56 78 9A BC DE F0 -> Mem_we at addr 12'h000 with data 32'h12345678, then at 12'h004 with data 32'h9ABCDEF0, then a single Done pulse; Error=0.
REQ-036 BIG_ENDIAN=0, Length=1, bytes 12 34 56 78 -> data 32'h78563412 at 12'h000.
REQ-037 Byte_valid toggled every other cycle -> identical writes; no byte is lost or duplicated; Byte_ready=0 during WRITE.
REQ-038 Length=0, and separately Length=1025 -> no Mem_we, Error=1, one Done pulse, Busy never asserted.
REQ-039 Length=3, Abort after 6 bytes -> exactly one write at 12'h000, no Done pulse, Error=1, Cpu_hold=0 next cycle; a following Start clears Error.
REQ-040 rst_n low for one cycle mid-RECV -> all outputs 0 asynchronously; after release, Start with Length=1 completes normally.
